// File: rtl/status_register_if.sv
// -----------------------------------------------------------------------------
// status_register_if
//
// Purpose:
//   Groups the write request and status outputs of status_register into one
//   bundle. The master side issues writes and observes the stored status. The
//   slave side is the register itself.
//
// Signals (all are plain logic nets or variables):
//   write_en        master -> slave  load new_state on the next rising clk edge
//   new_state       master -> slave  candidate state value (WIDTH bits)
//   current_state   slave  -> master registered stored state
//   state_changed   slave  -> master one-cycle pulse after a value-changing write
//   state_nonzero   slave  -> master high while current_state is non-zero
//   previous_state  slave  -> master value held before the last changing write
//
// Parameters:
//   WIDTH  data width in bits. It must match the WIDTH of the attached register.
// -----------------------------------------------------------------------------
interface status_register_if #(
  parameter int WIDTH = 8
);

  logic             write_en;
  logic [WIDTH-1:0] new_state;
  logic [WIDTH-1:0] current_state;
  logic             state_changed;
  logic             state_nonzero;
  logic [WIDTH-1:0] previous_state;

  modport master (
    output write_en,
    output new_state,
    input  current_state,
    input  state_changed,
    input  state_nonzero,
    input  previous_state
  );

  modport slave (
    input  write_en,
    input  new_state,
    output current_state,
    output state_changed,
    output state_nonzero,
    output previous_state
  );

endinterface : status_register_if

// File: rtl/status_register.sv
// -----------------------------------------------------------------------------
// status_register
//
// Purpose:
//   This block holds a WIDTH-bit status word, for example the game result:
//   8'h01 means player 1 won and 8'h02 means player 2 won.
//   - A write loads new_state at the next rising clk edge.
//   - state_changed pulses for one cycle only when the write altered the
//     stored value.
//   - state_nonzero is the OR of all bits of the stored value.
//   - Optionally, the block keeps the value that was replaced by the most
//     recent changing write.
//
// Ports:
//   clk   input   rising-edge clock for all state
//   rst   input   asynchronous, active-high reset. While it is high, every
//                 register is forced to its reset value and writes are ignored.
//   bus   status_register_if.slave
//         write_en, new_state      write request (inputs)
//         current_state            stored value (registered)
//         state_changed            one-cycle pulse after a changing write
//                                  (registered)
//         state_nonzero            |current_state (combinational)
//         previous_state           value before the last changing write
//
// Parameters:
//   WIDTH        state width in bits. It must match bus WIDTH.
//   RESET_VALUE  value loaded into current_state and previous_state on reset
//
// Configuration:
//   STATUS_REGISTER_HISTORY_EN
//     When defined, a history register captures the old current_state at each
//     changing write.
//     When undefined, previous_state is tied to RESET_VALUE and no history
//     register exists.
// -----------------------------------------------------------------------------
module status_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  status_register_if.slave  bus
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             changed_q;
  logic             changed_d;
  logic             write_changes;

  // A write only counts as an update when it alters the stored value. This
  // condition also qualifies the history capture, so rewriting the same value
  // leaves previous_state unchanged.
  assign write_changes = bus.write_en && (bus.new_state != state_q);

  always_comb begin
    state_d   = state_q;
    changed_d = 1'b0;
    if (write_changes) begin
      state_d   = bus.new_state;
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
    end
  end

`ifdef STATUS_REGISTER_HISTORY_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    prev_d = prev_q;
    if (write_changes) begin
      prev_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign bus.previous_state = prev_q;
`else
  assign bus.previous_state = RESET_VALUE;
`endif

  assign bus.current_state = state_q;
  assign bus.state_changed = changed_q;
  assign bus.state_nonzero = |state_q;

endmodule : status_register

// File: tb/tb_status_register.sv
module tb_status_register;

  localparam int WIDTH = 8;

  typedef struct {
    int              row;
    logic [WIDTH-1:0] cur;
    logic             chg;
    logic             nz;
    logic [WIDTH-1:0] prev;
  } exp_t;

  logic clk;
  logic rst;

  int n_compared;
  int n_mismatched;
  int row_idx;

  exp_t exp_q[$];

  status_register_if #(.WIDTH(WIDTH)) bus ();

  status_register #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input int row, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, req);
    end
  endtask

  task automatic check1(input string name, input int row, input logic act, input logic req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, act, req);
    end
  endtask

  // Monitor: sample away from the active edge. Each queued entry describes
  // the outputs that should be visible at the falling edge after its row was
  // driven.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check8("current_state",  e.row, bus.current_state,  e.cur);
      check1("state_changed",  e.row, bus.state_changed,  e.chg);
      check1("state_nonzero",  e.row, bus.state_nonzero,  e.nz);
      check8("previous_state", e.row, bus.previous_state, e.prev);
    end
  end

  // Drive one row 1 ns after a rising edge. The expected values are
  // hand-computed from earlier rows. They reflect writes taken at earlier
  // edges, and an async reset asserted in this row.
  // ep_hist is the previous_state expected with history tracking enabled.
  // Without history tracking, previous_state must equal RESET_VALUE (00).
  task automatic row(input logic r, input logic we, input logic [WIDTH-1:0] ns,
                     input logic [WIDTH-1:0] ec, input logic ech, input logic enz,
                     input logic [WIDTH-1:0] ep_hist);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.write_en  = we;
    bus.new_state = ns;
    e.row  = row_idx;
    e.cur  = ec;
    e.chg  = ech;
    e.nz   = enz;
`ifdef STATUS_REGISTER_HISTORY_EN
    e.prev = ep_hist;
`else
    e.prev = 8'h00;
`endif
    exp_q.push_back(e);
    row_idx++;
  endtask

  initial begin
    int waited;
    n_compared    = 0;
    n_mismatched  = 0;
    row_idx       = 0;
    rst           = 1'b1;
    bus.write_en  = 1'b0;
    bus.new_state = 8'h00;

    //   rst   we    ns      cur    chg   nz    prev(hist)
    row(1'b1, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h00); // write during reset
    row(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00); // AA was lost
    row(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00);
    row(1'b0, 1'b0, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h00); // player 1 won
    row(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00); // FF ignored
    row(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00);
    row(1'b0, 1'b1, 8'h02, 8'h01, 1'b0, 1'b1, 8'h00);
    row(1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 1'b1, 8'h01); // rewrite of 02 next
    row(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 8'h01); // no second pulse
    row(1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00); // reset between edges
    row(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00); // 55 was lost
    row(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00);
    row(1'b0, 1'b1, 8'h02, 8'h01, 1'b1, 1'b1, 8'h00); // back-to-back
    row(1'b0, 1'b1, 8'h80, 8'h02, 1'b1, 1'b1, 8'h01);
    row(1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 8'h02); // MSB only
    row(1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 8'h02);
    row(1'b0, 1'b1, 8'hFF, 8'h80, 1'b0, 1'b1, 8'h02);
    row(1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h80);
    row(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF); // change to zero
    row(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00); // mid-operation reset
    row(1'b0, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00);
    row(1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h00); // first write after release
    row(1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h00);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_status_register
